mixcol_addkey_serial: RTL and testbench
=======================================

Name: mixcol_addkey_serial

Overview:
Round-datapath stage directly downstream of ShiftRows in the AES-128 encrypt path. It consumes the 128-bit ShiftRows output plus the current round key and applies MixColumns, then AddRoundKey. In the final round, MixColumns is bypassed and only AddRoundKey is applied. Columns are processed serially to save area, and the block talks to its neighbours through valid/ready handshakes on both sides.

Parameters:
COLS_PER_CYCLE, 1, columns processed per CALC cycle. Legal values are 1, 2 and 4; anything else is an elaboration error.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream has a state/key pair
in_ready  out  1  block can accept input this cycle
state_in  in  128  ShiftRows output; byte 0 at [127:120]; column c = [127-32c -: 32]
round_key  in  128  round key, same byte/column order as state_in
last_round  in  1  1 = skip MixColumns (round 10)
out_valid  out  1  state_out holds a result
out_ready  in  1  downstream accepts result
state_out  out  128  round result, same byte order
busy  out  1  high in CALC or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: FSM = IDLE, out_valid = 0, state_out = 0, busy = 0, column counter = 0, captured regs = 0. in_ready = 1 during and after reset.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture state_in, round_key and last_round into internal regs; go to CALC with col = 0.
- CALC:
  - Each cycle, process columns col .. col+COLS_PER_CYCLE-1.
  - For each column, result = (last_round ? col_word : MixCol(col_word)) ^ key_word, written into the matching 32-bit slice of the result reg.
  - col advances by COLS_PER_CYCLE. After the cycle that processes column 3, go to DONE.
  - in_ready = 0 throughout CALC.
  - Inputs may change freely after the accepting handshake.
- MixCol(a0..a3), where a0 is the MSB byte of the column:
  - r0 = 2a0^3a1^a2^a3
  - r1 = a0^2a1^3a2^a3
  - r2 = a0^a1^2a2^3a3
  - r3 = 3a0^a1^a2^2a3
  - xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1B : 0); 3b = xtime(b)^b. All arithmetic is pure GF(2^8), 8-bit wide.
- DONE:
  - out_valid = 1; state_out = result reg, held stable until out_ready.
  - On out_ready & no new input: drop out_valid and go to IDLE.
  - On out_ready & in_valid: accept the new input in the same cycle and go straight to CALC. This means in_ready = (state==IDLE) | (state==DONE & out_ready), a combinational path from out_ready to in_ready by design.
  - state_out keeps its last value after out_valid falls; it is not cleared.
- Latency: 4/COLS_PER_CYCLE cycles. If the input is accepted at clock edge k, out_valid goes high after edge k + 4/COLS_PER_CYCLE.
- Throughput: one result per 4/COLS_PER_CYCLE + 1 cycles with out_ready held high.
- Back-pressure: out_ready low in DONE stalls indefinitely with all outputs stable.
- Reset mid-operation: any rst_n assertion aborts immediately. Partial results are discarded and all outputs return to their reset values.
- busy = (state != IDLE).

Decomposition:
- Shared package aes_pkg holds:
  - constant AES_POLY = 8'h1B
  - function xtime
  - function mixcol_word (32 -> 32)
  - function get_col (128-bit state, index -> 32)
- One combinational sub-module, mixcolumn_32 (32-bit column in, 32-bit out), instantiated COLS_PER_CYCLE times. It is reused by the later inverse path with a mode pin added there.

Test Plan:
- FIPS-197 columns, last_round = 0, round_key = 0: state_in = db135345_f20a225c_01010101_c6c6c6c6 -> state_out = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid 4 cycles after accept (COLS_PER_CYCLE = 1).
- FIPS-197 App. B round 1: state_in = d4bf5d30_e0b452ae_b84111f1_1e2798e5, round_key = a0fafe17_88542cb1_23a33939_2a6c7605 -> state_out = a49c7ff2_689f352b_6b5bea43_026a5049.
- last_round = 1: state_in = 0123456789abcdef_fedcba9876543210, round_key = ffffffff_ffffffff_00000000_00000000 -> state_out = fedcba98_76543210_fedcba98_76543210 (plain XOR, no MixColumns).
- Back-pressure and back-to-back:
  - Hold out_ready = 0 for 10 cycles in DONE -> state_out and out_valid stable, in_ready = 0.
  - Then raise out_ready with in_valid = 1 -> second vector accepted the same cycle, and the second result is correct 4 cycles later.
- Reset mid-CALC: deassert rst_n two cycles after accept -> out_valid = 0, state_out = 0, in_ready = 1 immediately. No stale result appears after reset is released.
- Repeat the first two scenarios with COLS_PER_CYCLE = 2 and 4 -> latency 2 and 1 respectively, identical results.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES helpers for the encrypt round datapath: GF(2^8) xtime, the
// MixColumns column transform, column extraction and the stage FSM encoding.
package aes_pkg;

    localparam logic [7:0]  AES_POLY = 8'h1B;
    localparam int unsigned COL_W    = 32;
    localparam int unsigned STATE_W  = 128;
    localparam int unsigned NCOLS    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Column transform; a0 is the most significant byte of the word.
    function automatic logic [31:0] mixcol_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        r0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        r3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {r0, r1, r2, r3};
    endfunction

    function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] idx);
        return s[STATE_W - 1 - COL_W * 32'(idx) -: COL_W];
    endfunction

endpackage

// File: rtl/mixcolumn_32.sv
// Combinational MixColumns on one 32-bit column.
module mixcolumn_32
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    assign o_col = mixcol_word(i_col);

endmodule

// File: rtl/mixcol_addkey_serial.sv
// AES encrypt round stage after ShiftRows: column-serial MixColumns (bypassed
// in the final round) followed by AddRoundKey, with valid/ready on both sides.
module mixcol_addkey_serial
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam int unsigned LAST_COL = NCOLS - COLS_PER_CYCLE;

    mc_state_e            r_fsm;
    mc_state_e            w_fsm_next;
    logic                 w_accept;
    logic                 w_last_step;
    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   r_key;
    logic [STATE_W-1:0]   r_result;
    logic [STATE_W-1:0]   r_state_out;
    logic [STATE_W-1:0]   w_next_result;
    logic                 r_last;
    logic                 r_out_valid;
    logic [1:0]           r_col;
    logic [1:0]           w_idx    [COLS_PER_CYCLE];
    logic [COL_W-1:0]     w_col_in [COLS_PER_CYCLE];
    logic [COL_W-1:0]     w_mc_out [COLS_PER_CYCLE];

    for (genvar gi = 0; gi < int'(COLS_PER_CYCLE); gi++) begin : g_col
        assign w_idx[gi]    = r_col + 2'(gi);
        assign w_col_in[gi] = get_col(r_state, w_idx[gi]);

        mixcolumn_32 u_mixcol (
            .i_col (w_col_in[gi]),
            .o_col (w_mc_out[gi])
        );
    end

    assign w_last_step = (r_col == 2'(LAST_COL));
    assign w_accept    = in_valid & in_ready;

    // Overlay this cycle's columns onto the partial result.
    always_comb begin
        w_next_result = r_result;
        for (int g = 0; g < int'(COLS_PER_CYCLE); g++) begin
            w_next_result[STATE_W - 1 - COL_W * 32'(w_idx[g]) -: COL_W] =
                (r_last ? w_col_in[g] : w_mc_out[g]) ^ get_col(r_key, w_idx[g]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // in_ready depends combinationally on out_ready in DONE so a new input
    // can be taken in the same cycle the result leaves.
    always_comb begin
        w_fsm_next = r_fsm;
        in_ready   = 1'b0;
        unique case (r_fsm)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_fsm_next = ST_CALC;
                end
            end
            ST_CALC: begin
                if (w_last_step) begin
                    w_fsm_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    in_ready   = 1'b1;
                    w_fsm_next = in_valid ? ST_CALC : ST_IDLE;
                end
            end
            default: begin
                w_fsm_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= '0;
            r_key       <= '0;
            r_last      <= 1'b0;
            r_col       <= '0;
            r_result    <= '0;
            r_state_out <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_state <= state_in;
                r_key   <= round_key;
                r_last  <= last_round;
                r_col   <= '0;
            end
            if (r_fsm == ST_CALC) begin
                r_result <= w_next_result;
                r_col    <= r_col + 2'(COLS_PER_CYCLE);
                if (w_last_step) begin
                    r_state_out <= w_next_result;
                    r_out_valid <= 1'b1;
                end
            end
            if (r_fsm == ST_DONE && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign state_out = r_state_out;
    assign busy      = (r_fsm != ST_IDLE);

endmodule

// File: tb/tb_mixcol_addkey_serial.sv
// Bench for mixcol_addkey_serial: one instance per legal COLS_PER_CYCLE,
// table-driven vectors with a scoreboard, plus back-pressure and reset sequences.
module tb_mixcol_addkey_serial;

    localparam int NDUT = 3;

    typedef struct {
        logic [127:0] s;
        logic [127:0] k;
        logic         last;
        logic [127:0] exp;
    } vec_t;

    typedef struct {
        logic [127:0] exp;
        int           acc;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid_a  [NDUT];
    logic         in_ready_a  [NDUT];
    logic         out_valid_a [NDUT];
    logic         out_ready_a [NDUT];
    logic         busy_a      [NDUT];
    logic [127:0] state_out_a [NDUT];
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic         last_round;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    vec_t vecs [5];
    sb_t  sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        mixcol_addkey_serial #(.COLS_PER_CYCLE(1 << gi)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid_a[gi]),
            .in_ready   (in_ready_a[gi]),
            .state_in   (state_in),
            .round_key  (round_key),
            .last_round (last_round),
            .out_valid  (out_valid_a[gi]),
            .out_ready  (out_ready_a[gi]),
            .state_out  (state_out_a[gi]),
            .busy       (busy_a[gi])
        );
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive a vector at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int d, input vec_t v);
        int t;
        state_in      = v.s;
        round_key     = v.k;
        last_round    = v.last;
        in_valid_a[d] = 1'b1;
        #1;
        t = 0;
        while (in_ready_a[d] !== 1'b1 && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 50) begin
            check($sformatf("accept_timeout_d%0d", d), 128'(in_ready_a[d]), 128'(1));
            in_valid_a[d] = 1'b0;
            return;
        end
        sb.push_back('{v.exp, cyc + 1});
        @(negedge clk);
        in_valid_a[d] = 1'b0;
    endtask

    // Wait for a result, compare latency and data against the scoreboard.
    task automatic receive(input int d);
        int  t;
        sb_t e;
        out_ready_a[d] = 1'b1;
        t = 0;
        while (out_valid_a[d] !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50 || sb.size() == 0) begin
            check($sformatf("result_timeout_d%0d", d), 128'(out_valid_a[d]), 128'(1));
            sb.delete();
            out_ready_a[d] = 1'b0;
            return;
        end
        e = sb.pop_front();
        check($sformatf("latency_d%0d", d), 128'(cyc - e.acc), 128'(4 >> d));
        check($sformatf("data_d%0d", d), state_out_a[d], e.exp);
        @(negedge clk);
        check($sformatf("valid_drop_d%0d", d), 128'(out_valid_a[d]), 128'(0));
        out_ready_a[d] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sb_t e;
        int  t;
        logic seen;

        vecs[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h0, 1'b0,
                    128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
        vecs[1] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5,
                    128'ha0fafe17_88542cb1_23a33939_2a6c7605, 1'b0,
                    128'ha49c7ff2_689f352b_6b5bea43_026a5049};
        vecs[2] = '{128'h01234567_89abcdef_fedcba98_76543210,
                    128'hffffffff_ffffffff_00000000_00000000, 1'b1,
                    128'hfedcba98_76543210_fedcba98_76543210};
        vecs[3] = '{128'h0, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b0,
                    128'h00112233_44556677_8899aabb_ccddeeff};
        vecs[4] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h0, 1'b1,
                    128'hdb135345_f20a225c_01010101_c6c6c6c6};

        rst_n      = 1'b0;
        state_in   = '0;
        round_key  = '0;
        last_round = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            in_valid_a[d]  = 1'b0;
            out_ready_a[d] = 1'b0;
        end

        #12;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_out_valid_d%0d", d), 128'(out_valid_a[d]), 128'(0));
            check($sformatf("rst_state_out_d%0d", d), state_out_a[d], 128'h0);
            check($sformatf("rst_in_ready_d%0d", d), 128'(in_ready_a[d]), 128'(1));
            check($sformatf("rst_busy_d%0d", d), 128'(busy_a[d]), 128'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 5; i++) begin
                send(d, vecs[i]);
                receive(d);
            end
        end

        // Back-pressure in DONE, then back-to-back accept on release.
        send(0, vecs[1]);
        t = 0;
        while (out_valid_a[0] !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("bp_reach_done", 128'(out_valid_a[0]), 128'(1));
        state_in      = vecs[0].s;
        round_key     = vecs[0].k;
        last_round    = vecs[0].last;
        in_valid_a[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 128'(out_valid_a[0]), 128'(1));
            check("bp_state_out", state_out_a[0], vecs[1].exp);
            check("bp_in_ready", 128'(in_ready_a[0]), 128'(0));
        end
        out_ready_a[0] = 1'b1;
        #1;
        check("b2b_in_ready", 128'(in_ready_a[0]), 128'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("b2b_first_data", state_out_a[0], e.exp);
        end else begin
            check("b2b_sb_empty", 128'(sb.size()), 128'(1));
        end
        sb.push_back('{vecs[0].exp, cyc + 1});
        @(negedge clk);
        in_valid_a[0]  = 1'b0;
        out_ready_a[0] = 1'b0;
        check("b2b_valid_low", 128'(out_valid_a[0]), 128'(0));
        check("b2b_busy", 128'(busy_a[0]), 128'(1));
        receive(0);

        // Reset asserted two cycles after accept, in the middle of CALC.
        send(0, vecs[2]);
        @(negedge clk);
        check("pre_rst_busy", 128'(busy_a[0]), 128'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(out_valid_a[0]), 128'(0));
        check("mid_rst_state_out", state_out_a[0], 128'h0);
        check("mid_rst_in_ready", 128'(in_ready_a[0]), 128'(1));
        check("mid_rst_busy", 128'(busy_a[0]), 128'(0));
        sb.delete();
        @(negedge clk);
        rst_n          = 1'b1;
        out_ready_a[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid_a[0] === 1'b1) seen = 1'b1;
        end
        check("no_stale_result", 128'(seen), 128'(0));
        check("post_rst_state_out", state_out_a[0], 128'h0);
        out_ready_a[0] = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
